// File: rtl/iir2_filter_pkg.sv
// Shared definitions for the biquad IIR datapath: default word width,
// coefficient field positions and the fixed-point product rescale.
package iir2_filter_pkg;

    localparam int NB_DEFAULT = 12;

    // Field index of each coefficient within its packed bus, in units of NB bits.
    localparam int B0_FIELD = 2;
    localparam int B1_FIELD = 1;
    localparam int B2_FIELD = 0;
    localparam int A1_FIELD = 1;
    localparam int A2_FIELD = 0;

    // Full-precision signed multiply followed by an arithmetic right shift
    // (floor toward -inf). Operands are pre-sign-extended to 32 bits.
    function automatic logic signed [63:0] fxp_scale(
        input logic signed [31:0] x,
        input logic signed [31:0] y,
        input int                 frac
    );
        logic signed [63:0] xe;
        logic signed [63:0] ye;
        xe = 64'(x);
        ye = 64'(y);
        return (xe * ye) >>> frac;
    endfunction

endpackage

// File: rtl/iir2_filter_fxp_mul.sv
// Signed NB x NB multiplier with Q1.(NB-1) rescale; result kept at NB+2 bits
// so the downstream three-term sums have headroom before wrapping.
module fxp_mul
    import iir2_filter_pkg::*;
#(
    parameter int NB = NB_DEFAULT
) (
    input  logic signed [NB-1:0] x,
    input  logic signed [NB-1:0] y,
    output logic signed [NB+1:0] p
);

    assign p = (NB+2)'(fxp_scale(32'(x), 32'(y), NB - 1));

endmodule

// File: rtl/iir2_filter.sv
// Direct Form II biquad: w[n] = x - a1*w1 - a2*w2, y[n] = b0*w + b1*w1 + b2*w2.
// One sample per vIn strobe, one cycle latency, coefficients read combinationally.
module iir2_filter
    import iir2_filter_pkg::*;
#(
    parameter int NB = NB_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 vIn,
    input  logic signed [NB-1:0] dIn,
    input  logic [3*NB-1:0]      b,
    input  logic [2*NB-1:0]      a,
    output logic signed [NB-1:0] dOut,
    output logic                 vOut
);

    logic signed [NB-1:0] b0, b1, b2, a1, a2;
    logic signed [NB-1:0] w1, w2, w_n, y_n;
    logic signed [NB+1:0] m_a1, m_a2, m_b0, m_b1, m_b2;
    logic signed [NB+1:0] x_ext;

    assign b0 = b[B0_FIELD*NB +: NB];
    assign b1 = b[B1_FIELD*NB +: NB];
    assign b2 = b[B2_FIELD*NB +: NB];
    assign a1 = a[A1_FIELD*NB +: NB];
    assign a2 = a[A2_FIELD*NB +: NB];

    assign x_ext = (NB+2)'(dIn);

    fxp_mul #(.NB(NB)) u_mul_a1 (.x(a1), .y(w1),  .p(m_a1));
    fxp_mul #(.NB(NB)) u_mul_a2 (.x(a2), .y(w2),  .p(m_a2));
    fxp_mul #(.NB(NB)) u_mul_b0 (.x(b0), .y(w_n), .p(m_b0));
    fxp_mul #(.NB(NB)) u_mul_b1 (.x(b1), .y(w1),  .p(m_b1));
    fxp_mul #(.NB(NB)) u_mul_b2 (.x(b2), .y(w2),  .p(m_b2));

    // Feedback path: new delay-line value, wrapped to NB bits.
    always_comb begin
        w_n = NB'(x_ext - m_a1 - m_a2);
    end

    // Feedforward path: filter output, wrapped to NB bits.
    always_comb begin
        y_n = NB'(m_b0 + m_b1 + m_b2);
    end

    // Advance the delay line and register the output on each valid sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w1   <= '0;
            w2   <= '0;
            dOut <= '0;
            vOut <= 1'b0;
        end else begin
            vOut <= vIn;
            if (vIn) begin
                w2   <= w1;
                w1   <= w_n;
                dOut <= y_n;
            end
        end
    end

endmodule

// File: tb/tb_iir2_filter.sv
// Scoreboard bench for iir2_filter (NB=12): an integer reference model
// pushes expected outputs when a sample is driven; a monitor pops and
// compares them one clock later, and checks hold/reset behaviour otherwise.
module tb_iir2_filter;

    localparam int NB    = 12;
    localparam int NOLIT = -99999;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 vIn = 1'b0;
    logic signed [NB-1:0] dIn = '0;
    logic [3*NB-1:0]      b   = '0;
    logic [2*NB-1:0]      a   = '0;
    logic signed [NB-1:0] dOut;
    logic                 vOut;

    int checks = 0;
    int errors = 0;

    int sb_exp[$];
    int sb_lit[$];

    // reference model state and coefficients
    int m_w1 = 0, m_w2 = 0;
    int c_b0 = 0, c_b1 = 0, c_b2 = 0, c_a1 = 0, c_a2 = 0;

    iir2_filter #(.NB(NB)) dut (
        .clk  (clk),
        .rst  (rst),
        .vIn  (vIn),
        .dIn  (dIn),
        .b    (b),
        .a    (a),
        .dOut (dOut),
        .vOut (vOut)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int wrap12(input int v);
        int r;
        r = (v + 2048) % 4096;
        if (r < 0) r += 4096;
        return r - 2048;
    endfunction

    function automatic int fmul(input int c, input int v);
        int p;
        p = c * v;
        return p >>> 11;
    endfunction

    task automatic set_coef(input int b0_, input int b1_, input int b2_,
                            input int a1_, input int a2_);
        c_b0 = b0_; c_b1 = b1_; c_b2 = b2_; c_a1 = a1_; c_a2 = a2_;
        b = {12'(b0_), 12'(b1_), 12'(b2_)};
        a = {12'(a1_), 12'(a2_)};
    endtask

    // Called at a negedge: drive one cycle of stimulus, update model, advance.
    task automatic drive(input int x, input bit v, input int lit);
        int w, y;
        dIn = 12'(x);
        vIn = v;
        if (v) begin
            w = wrap12(x - fmul(c_a1, m_w1) - fmul(c_a2, m_w2));
            y = wrap12(fmul(c_b0, w) + fmul(c_b1, m_w1) + fmul(c_b2, m_w2));
            m_w2 = m_w1;
            m_w1 = w;
            sb_exp.push_back(y);
            sb_lit.push_back(lit);
        end
        @(negedge clk);
    endtask

    task automatic pulse_reset();
        vIn = 1'b0;
        rst = 1'b1;
        m_w1 = 0;
        m_w2 = 0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Monitor: inputs sampled at the edge, outputs checked 1 time unit later.
    logic mon_v, mon_r;
    int   last_dout = 0;
    always @(posedge clk) begin
        int e, l;
        mon_v = vIn;
        mon_r = rst;
        #1;
        if (mon_r) begin
            check("rst_vout", int'(vOut), 0);
            check("rst_dout", int'(dOut), 0);
            last_dout = 0;
        end else begin
            check("vout", int'(vOut), int'(mon_v));
            if (mon_v) begin
                if (sb_exp.size() == 0) begin
                    check("sb_underflow", 1, 0);
                end else begin
                    e = sb_exp.pop_front();
                    l = sb_lit.pop_front();
                    check("dout", int'(dOut), e);
                    if (l != NOLIT) check("dout_spec", int'(dOut), l);
                    last_dout = e;
                end
            end else begin
                check("hold", int'(dOut), last_dout);
            end
        end
    end

    initial begin
        // Reset held with vIn toggling
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            dIn = 12'(100 * i);
            vIn = ~vIn;
            @(negedge clk);
        end
        vIn = 1'b0;
        rst = 1'b0;
        @(negedge clk);

        // First sample after reset: zero state
        set_coef(1024, 0, 0, 0, 0);
        drive(1000, 1'b1, 500);
        drive(0, 1'b0, NOLIT);

        // Impulse with feedback
        pulse_reset();
        set_coef(1024, 0, 0, -1024, 0);
        drive(1000, 1'b1, 500);
        drive(0, 1'b1, 250);
        drive(0, 1'b1, 125);
        drive(0, 1'b1, 62);
        drive(0, 1'b0, NOLIT);

        // FIR taps
        pulse_reset();
        set_coef(1024, 1024, 1024, 0, 0);
        for (int i = 0; i < 4; i++) begin
            int lits[4] = '{200, 400, 600, 600};
            drive(400, 1'b1, lits[i]);
        end
        drive(0, 1'b0, NOLIT);

        // Valid gating: state and output hold while vIn is low
        pulse_reset();
        set_coef(1024, 0, 0, -1024, 0);
        drive(1000, 1'b1, 500);
        drive(0, 1'b1, 250);
        drive(0, 1'b0, NOLIT);
        drive(0, 1'b0, NOLIT);
        drive(0, 1'b0, NOLIT);
        check("gate_hold", int'(dOut), 250);
        drive(0, 1'b1, 125);
        drive(0, 1'b0, NOLIT);

        // Negative rounding (floor)
        set_coef(1024, 0, 0, 0, 0);
        drive(-3, 1'b1, -2);
        drive(0, 1'b0, NOLIT);

        // Asynchronous reset mid-stream
        pulse_reset();
        set_coef(1024, 0, 0, -1024, 0);
        drive(1000, 1'b1, 500);
        drive(0, 1'b1, 250);
        vIn = 1'b0;
        #2;
        rst = 1'b1;
        m_w1 = 0;
        m_w2 = 0;
        #1;
        check("async_rst_dout", int'(dOut), 0);
        check("async_rst_vout", int'(vOut), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        drive(0, 1'b1, 0);
        drive(0, 1'b0, NOLIT);

        // Random coefficients and samples with random vIn gating
        pulse_reset();
        for (int blk = 0; blk < 4; blk++) begin
            set_coef($urandom_range(4095) - 2048, $urandom_range(4095) - 2048,
                     $urandom_range(4095) - 2048, $urandom_range(2047) - 1024,
                     $urandom_range(1023) - 512);
            for (int i = 0; i < 25; i++) begin
                drive($urandom_range(4095) - 2048, 1'($urandom_range(3) != 0), NOLIT);
            end
        end
        drive(0, 1'b0, NOLIT);
        drive(0, 1'b0, NOLIT);

        check("sb_drained", sb_exp.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
